// File: rtl/serial_pattern_detector.sv
// Counts occurrences of a fixed bit pattern in a serial frame of FRAME_LEN bits.
// Results are registered and held in DONE until the next start.
module serial_pattern_detector #(
  parameter int unsigned PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned FRAME_LEN = 10,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] PAT_M1 = 4'(PAT_LEN - 1);
  localparam logic [3:0] PAT_L  = 4'(PAT_LEN);
  localparam logic [3:0] LAST   = 4'(FRAME_LEN - 1);

  state_t             state_q;
  logic [PAT_LEN-1:0] win_q;
  logic [PAT_LEN-1:0] win_d;
  logic [3:0]         fill_q;
  logic [3:0]         bcnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               det_q;
  logic               busy_q;
  logic               done_q;
  logic               hit;

  assign win_d = {win_q[PAT_LEN-2:0], bit_in};
  assign hit   = (win_d == PATTERN) && (fill_q >= PAT_M1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      det_q <= 1'b0;
      // start restarts from any state and drops a coincident bit
      if (start) begin
        state_q <= RUN;
        win_q   <= '0;
        fill_q  <= '0;
        bcnt_q  <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (state_q == RUN && bit_valid) begin
        win_q  <= win_d;
        bcnt_q <= bcnt_q + 4'd1;
        if (hit) begin
          det_q <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
        if (hit && OVERLAP == 0) begin
          fill_q <= '0;
        end else if (fill_q != PAT_L) begin
          fill_q <= fill_q + 4'd1;
        end
        if (bcnt_q == LAST) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign detect      = det_q;
  assign match_count = cnt_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule
